// File: rtl/rv32m_divider.sv
// RV32M divide/remainder unit (DIV, DIVU, REM, REMU) using radix-2 restoring division.
// Latency: normal ops 33 cycles accept-to-done (32 in CALC + 1 in DONE); div-by-zero and signed overflow 1 cycle.
// Backpressure: none; start is ignored while busy or when funct3[2]=0, and the caller retries after done.
//
// Ports:
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   start, funct3, rd        request pulse, op select (100 DIV, 101 DIVU, 110 REM, 111 REMU), destination index
//   rs1_val, rs2_val         dividend and divisor
//   busy, done               in-flight flag and one-cycle completion pulse
//   result, rd_out           quotient/remainder and destination index, held until the next done
//   reg_write                done qualified by rd_out != x0
module rv32m_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        reg_write
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;

  logic [32:0] rem_q;      // partial remainder; bit 32 absorbs the trial-subtraction borrow
  logic [31:0] quo_q;      // dividend magnitude shifting out, quotient bits shifting in
  logic [31:0] dvsr_q;     // divisor magnitude
  logic [5:0]  cnt_q;
  logic        rem_op_q;
  logic        neg_q_q;    // negate the quotient at the end
  logic        neg_r_q;    // negate the remainder at the end
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic [4:0]  rd_out_q;

  // Request decode
  logic        is_signed;
  logic        accept;
  logic        div_zero;
  logic        overflow;
  logic        special;
  logic [31:0] special_res;
  logic [31:0] mag1;
  logic [31:0] mag2;

  assign is_signed = ~funct3[0];
  assign accept    = start && (state_q == IDLE) && funct3[2];
  assign div_zero  = (rs2_val == 32'h0);
  assign overflow  = is_signed && (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
  assign special   = div_zero || overflow;

  always_comb begin
    special_res = 32'h0;
    if (div_zero) begin
      special_res = funct3[1] ? rs1_val : 32'hFFFF_FFFF;
    end else begin
      special_res = funct3[1] ? 32'h0 : 32'h8000_0000;
    end
  end

  assign mag1 = (is_signed && rs1_val[31]) ? (~rs1_val + 32'd1) : rs1_val;
  assign mag2 = (is_signed && rs2_val[31]) ? (~rs2_val + 32'd1) : rs2_val;

  // One restoring step. Since rem < divisor, the 33-bit trial never reaches 2^32 + divisor,
  // so diff[32] is a reliable borrow flag.
  logic [32:0] trial;
  logic [32:0] diff;
  logic        fits;
  logic [32:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] q_final;
  logic [31:0] r_final;

  assign trial   = {rem_q[31:0], quo_q[31]};
  assign diff    = trial - {1'b0, dvsr_q};
  assign fits    = ~diff[32];
  assign rem_nx  = fits ? diff : trial;
  assign quo_nx  = {quo_q[30:0], fits};
  assign q_final = neg_q_q ? (~quo_nx + 32'd1) : quo_nx;
  assign r_final = neg_r_q ? (~rem_nx[31:0] + 32'd1) : rem_nx[31:0];

  // Top remainder bit is always zero after a restore; it only exists in the register
  // so the borrow has a home during the trial subtraction.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[32];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (cnt_q == 6'd31) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= 33'h0;
      quo_q    <= 32'h0;
      dvsr_q   <= 32'h0;
      cnt_q    <= 6'h0;
      rem_op_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      rd_q     <= 5'h0;
      result_q <= 32'h0;
      rd_out_q <= 5'h0;
    end else if (accept) begin
      rem_q    <= 33'h0;
      quo_q    <= mag1;
      dvsr_q   <= mag2;
      cnt_q    <= 6'h0;
      rem_op_q <= funct3[1];
      neg_q_q  <= is_signed && (rs1_val[31] ^ rs2_val[31]);
      neg_r_q  <= is_signed && rs1_val[31];
      rd_q     <= rd;
      if (special) begin
        result_q <= special_res;
        rd_out_q <= rd;
      end
    end else if (state_q == CALC) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + 6'd1;
      if (cnt_q == 6'd31) begin
        result_q <= rem_op_q ? r_final : q_final;
        rd_out_q <= rd_q;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign rd_out    = rd_out_q;
  assign reg_write = done && (rd_out_q != 5'h0);

endmodule

// File: tb/tb_rv32m_divider.sv
// Directed bench for rv32m_divider: vector table of ops with hand-computed results,
// plus hand sequences for reset, ignored starts and abort mid-operation.
// Latency n counts samples taken #1 after each edge, n=1 being the accepting edge.
module tb_rv32m_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        reg_write;

  int total = 0;
  int bad   = 0;

  rv32m_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .funct3    (funct3),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .rd        (rd),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .reg_write (reg_write)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  r;
    logic [31:0] exp_res;
    int          exp_lat;
    logic        exp_rw;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive a request on the falling edge; returns after the accepting edge sample (n=1).
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r);
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done starting from sample index n0, then check the completion
  // and that the unit is idle the following cycle with result held.
  task automatic finish_op(input string nm, input int n0, input logic [31:0] exp_res,
                           input logic [4:0] exp_rd, input int exp_lat, input logic exp_rw);
    int n;
    int nbusy;
    n = n0;
    nbusy = busy ? 1 : 0;
    while (!done && n < 64) begin
      @(posedge clk); #1;
      n++;
      if (busy) nbusy++;
    end
    check({nm, "/lat"}, n, exp_lat);
    check({nm, "/busy_cycles"}, nbusy, exp_lat - n0 + 1);
    check({nm, "/result"}, result, exp_res);
    check({nm, "/rd_out"}, {27'h0, rd_out}, {27'h0, exp_rd});
    check({nm, "/reg_write"}, {31'h0, reg_write}, {31'h0, exp_rw});
    @(posedge clk); #1;
    check({nm, "/done_1cyc"}, {31'h0, done}, 32'h0);
    check({nm, "/idle"}, {31'h0, busy}, 32'h0);
    check({nm, "/held"}, result, exp_res);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; funct3 = 3'b000; rs1_val = 32'h0; rs2_val = 32'h0; rd = 5'h0;

    //            funct3  rs1           rs2           rd     result        lat rw
    tbl[0]  = '{F_DIV,  32'd100,      32'd7,        5'd3,  32'h0000000E, 33, 1'b1};
    tbl[1]  = '{F_REM,  32'hFFFFFFF9, 32'd2,        5'd1,  32'hFFFFFFFF, 33, 1'b1};
    tbl[2]  = '{F_DIV,  32'hFFFFFFF9, 32'd2,        5'd2,  32'hFFFFFFFD, 33, 1'b1};
    tbl[3]  = '{F_DIVU, 32'hFFFFFFFF, 32'd0,        5'd4,  32'hFFFFFFFF, 1,  1'b1};
    tbl[4]  = '{F_REMU, 32'hFFFFFFFF, 32'd0,        5'd4,  32'hFFFFFFFF, 1,  1'b1};
    tbl[5]  = '{F_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd5,  32'h80000000, 1,  1'b1};
    tbl[6]  = '{F_DIVU, 32'd50,       32'd5,        5'd0,  32'd10,       33, 1'b0};
    tbl[7]  = '{F_REM,  32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h00000000, 1,  1'b1};
    tbl[8]  = '{F_DIVU, 32'hFFFFFFFF, 32'd1,        5'd8,  32'hFFFFFFFF, 33, 1'b1};
    tbl[9]  = '{F_REMU, 32'd1000,     32'd3,        5'd9,  32'd1,        33, 1'b1};
    tbl[10] = '{F_DIV,  32'd7,        32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 33, 1'b1};
    tbl[11] = '{F_REM,  32'd7,        32'hFFFFFFFE, 5'd11, 32'd1,        33, 1'b1};
    tbl[12] = '{F_REM,  32'hFFFFFFF9, 32'd0,        5'd12, 32'hFFFFFFF9, 1,  1'b1};
    tbl[13] = '{F_DIVU, 32'd3,        32'd7,        5'd13, 32'd0,        33, 1'b1};
    tbl[14] = '{F_REMU, 32'd3,        32'd7,        5'd14, 32'd3,        33, 1'b1};
    tbl[15] = '{F_DIV,  32'h80000000, 32'd2,        5'd15, 32'hC0000000, 33, 1'b1};
    tbl[16] = '{F_REM,  32'h80000000, 32'd3,        5'd16, 32'hFFFFFFFE, 33, 1'b1};
    tbl[17] = '{F_DIVU, 32'hDEADBEEF, 32'h10,       5'd31, 32'h0DEADBEE, 33, 1'b1};

    // Reset state, with a start attempted through a clock edge while in reset
    start = 1'b1; funct3 = F_DIVU; rs1_val = 32'd9; rs2_val = 32'd3; rd = 5'd1;
    #12;
    check("rst/busy", {31'h0, busy}, 32'h0);
    check("rst/done", {31'h0, done}, 32'h0);
    check("rst/reg_write", {31'h0, reg_write}, 32'h0);
    check("rst/result", result, 32'h0);
    check("rst/rd_out", {27'h0, rd_out}, 32'h0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, issued back-to-back at the minimum spacing
    for (int i = 0; i < 18; i++) begin
      issue(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].r);
      finish_op($sformatf("v%0d", i), 1, tbl[i].exp_res, tbl[i].r, tbl[i].exp_lat, tbl[i].exp_rw);
    end

    // Non-divide funct3 is ignored
    issue(3'b000, 32'd100, 32'd5, 5'd3);
    check("nondiv/busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    check("nondiv/done", {31'h0, done}, 32'h0);
    check("nondiv/result_held", result, 32'h0DEADBEE);

    // Reset mid-CALC aborts with no done pulse
    begin
      int seen_done;
      issue(F_DIVU, 32'd1000, 32'd3, 5'd7);
      repeat (9) begin
        @(posedge clk); #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("abort/busy", {31'h0, busy}, 32'h0);
      check("abort/result", result, 32'h0);
      check("abort/rd_out", {27'h0, rd_out}, 32'h0);
      seen_done = 0;
      repeat (30) begin
        @(posedge clk); #1;
        if (done || reg_write) seen_done++;
      end
      check("abort/no_done", seen_done, 0);
    end

    // First start after reset release is accepted on the first edge
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; funct3 = F_DIVU; rs1_val = 32'd1000; rs2_val = 32'd3; rd = 5'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("post_rst/accept", {31'h0, busy}, 32'h1);
    finish_op("post_rst", 1, 32'd333, 5'd7, 33, 1'b1);

    // A start while busy is ignored; the first operation completes unchanged
    issue(F_DIVU, 32'd1000, 32'd3, 5'd7);
    repeat (5) begin
      @(posedge clk); #1;
    end
    issue(F_DIVU, 32'd9, 32'd3, 5'd9);
    finish_op("busy_ign", 7, 32'd333, 5'd7, 33, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
